// File: rtl/st7735_pkg.sv
// st7735_pkg: shared constants for the ST7735 SPI receive model.
//   - Controller opcodes recognised by the decoder.
//   - Decoder FSM state enum.
//   - Bit positions of the sampled SPI pins in the synchronizer vector.
package st7735_pkg;

  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_INVOFF  = 8'h20;
  localparam logic [7:0] OP_INVON   = 8'h21;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;
  localparam logic [7:0] OP_COLMOD  = 8'h3A;

  localparam int PIN_SCL  = 3;
  localparam int PIN_CS   = 2;
  localparam int PIN_DC   = 1;
  localparam int PIN_MOSI = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_RASET_P,
    ST_RAMWR_HI,
    ST_RAMWR_LO,
    ST_SKIP
  } dec_state_e;

endpackage

// File: rtl/st7735_spi_rx_if.sv
// st7735_spi_rx_if: 4-wire SPI LCD link (SCL, CS active-low, DC, MOSI).
//   master modport: the driving side (init/pixel-stream engine or bench).
//   slave  modport: the receiving panel model.
interface st7735_spi_rx_if;
  logic SCL;
  logic CS;
  logic DC;
  logic MOSI;

  modport master (output SCL, CS, DC, MOSI);
  modport slave  (input  SCL, CS, DC, MOSI);
endinterface

// File: rtl/st7735_spi_rx_byte.sv
// spi_byte_rx: SPI byte assembler for the ST7735 receive model.
//   CLK, RST_N       : system clock, synchronous active-low reset
//   spi (slave)      : asynchronous SPI pins
//   byte_valid_o     : one-cycle strobe per completed byte
//   byte_o           : received byte (MSB first)
//   byte_is_cmd_o    : DC was low at the 8th SCL rise
module spi_byte_rx
  import st7735_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST_N,
  st7735_spi_rx_if.slave        spi,
  output logic                  byte_valid_o,
  output logic [7:0]            byte_o,
  output logic                  byte_is_cmd_o
);

  logic [3:0]       pins;
  // Stages 0/1 are the synchronizer; stage 2 re-times every pin so the
  // 8th-rise strobe lands three cycles after first capture and so MOSI/DC/CS
  // are sampled from the same CLK edge that first saw the SCL rise.
  logic [2:0][3:0]  sync_q;
  logic [3:0]       s;
  logic             scl_prev_q;
  logic             armed_q;
  logic [2:0]       cnt_q;
  logic [6:0]       shreg_q;
  logic             rise;

  assign pins = {spi.SCL, spi.CS, spi.DC, spi.MOSI};
  assign s    = sync_q[2];
  assign rise = s[PIN_SCL] & ~scl_prev_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q        <= '0;
      scl_prev_q    <= 1'b0;
      armed_q       <= 1'b0;
      cnt_q         <= '0;
      shreg_q       <= '0;
      byte_valid_o  <= 1'b0;
      byte_o        <= '0;
      byte_is_cmd_o <= 1'b0;
    end else begin
      sync_q       <= {sync_q[1:0], pins};
      scl_prev_q   <= s[PIN_SCL];
      byte_valid_o <= 1'b0;
      // CS high drops any partial byte, and wins over a coincident SCL rise.
      if (s[PIN_CS]) begin
        armed_q <= 1'b1;
        cnt_q   <= '0;
      end else if (rise && armed_q) begin
        shreg_q <= {shreg_q[5:0], s[PIN_MOSI]};
        if (cnt_q == 3'd7) begin
          byte_o        <= {shreg_q, s[PIN_MOSI]};
          byte_is_cmd_o <= ~s[PIN_DC];
          byte_valid_o  <= 1'b1;
          cnt_q         <= '0;
        end else begin
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/st7735_spi_rx.sv
// st7735_spi_rx: receive-side ST7735 panel model. Assembles SPI bytes,
// decodes CASET/RASET/RAMWR into addressed RGB565 pixel writes.
//   CLK, RST_N                  : clock, synchronous active-low reset
//   spi (slave)                 : SPI pins (SCL, CS, DC, MOSI)
//   BYTE_VALID/BYTE/BYTE_IS_CMD : per-byte strobe, data, command flag
//   PIX_VALID/PIX_X/PIX_Y/PIX_DATA : per-pixel strobe, address, colour
//   SLEEP_OUT/DISP_ON/INV_ON/COLMOD : panel status
// Build option: define ST7735_RX_STATUS_EN to implement the status
// registers; otherwise the status outputs are tied to 0.
module st7735_spi_rx
  import st7735_pkg::*;
#(
  parameter int X_W = 8,
  parameter int Y_W = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  st7735_spi_rx_if.slave  spi,
  output logic            BYTE_VALID,
  output logic [7:0]      BYTE,
  output logic            BYTE_IS_CMD,
  output logic            PIX_VALID,
  output logic [X_W-1:0]  PIX_X,
  output logic [Y_W-1:0]  PIX_Y,
  output logic [15:0]     PIX_DATA,
  output logic            SLEEP_OUT,
  output logic            DISP_ON,
  output logic            INV_ON,
  output logic [7:0]      COLMOD
);

  spi_byte_rx u_byte_rx (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .spi           (spi),
    .byte_valid_o  (BYTE_VALID),
    .byte_o        (BYTE),
    .byte_is_cmd_o (BYTE_IS_CMD)
  );

  dec_state_e       state_q;
  logic [1:0]       pidx_q;
  logic [2:0][7:0]  prm_q;   // last three params, [2] oldest
  logic [7:0]       hi_q;
  logic [X_W-1:0]   xs_q, xe_q, x_q, x_d, pix_x_q, win_xs, win_xe;
  logic [Y_W-1:0]   ys_q, ye_q, y_q, y_d, pix_y_q, win_ys, win_ye;
  logic             pix_vld_q;
  logic [15:0]      pix_data_q;

  // Window values assembled when p3 arrives: start={p0,p1}, end={p2,p3}.
  assign win_xs = X_W'({prm_q[2], prm_q[1]});
  assign win_xe = X_W'({prm_q[0], BYTE});
  assign win_ys = Y_W'({prm_q[2], prm_q[1]});
  assign win_ye = Y_W'({prm_q[0], BYTE});

  // Raster advance; equality-only wrap so XS>XE walks through 0.
  always_comb begin
    x_d = x_q + X_W'(1);
    y_d = y_q;
    if (x_q == xe_q) begin
      x_d = xs_q;
      y_d = (y_q == ye_q) ? ys_q : y_q + Y_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      pidx_q     <= '0;
      prm_q      <= '0;
      hi_q       <= '0;
      xs_q       <= '0;
      xe_q       <= '1;
      ys_q       <= '0;
      ye_q       <= '1;
      x_q        <= '0;
      y_q        <= '0;
      pix_vld_q  <= 1'b0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      pix_data_q <= '0;
    end else begin
      pix_vld_q <= 1'b0;
      if (BYTE_VALID) begin
        if (BYTE_IS_CMD) begin
          // Any command aborts the current state; a pending high byte is lost.
          pidx_q <= '0;
          case (BYTE)
            OP_CASET: state_q <= ST_CASET_P;
            OP_RASET: state_q <= ST_RASET_P;
            OP_RAMWR: begin
              state_q <= ST_RAMWR_HI;
              x_q     <= xs_q;
              y_q     <= ys_q;
            end
            default:  state_q <= ST_SKIP;
          endcase
        end else begin
          case (state_q)
            ST_CASET_P, ST_RASET_P: begin
              prm_q  <= {prm_q[1:0], BYTE};
              pidx_q <= pidx_q + 2'd1;
              if (pidx_q == 2'd3) begin
                state_q <= ST_SKIP;
                if (state_q == ST_CASET_P) begin
                  xs_q <= win_xs;
                  xe_q <= win_xe;
                end else begin
                  ys_q <= win_ys;
                  ye_q <= win_ye;
                end
              end
            end
            ST_RAMWR_HI: begin
              hi_q    <= BYTE;
              state_q <= ST_RAMWR_LO;
            end
            ST_RAMWR_LO: begin
              pix_vld_q  <= 1'b1;
              pix_x_q    <= x_q;
              pix_y_q    <= y_q;
              pix_data_q <= {hi_q, BYTE};
              x_q        <= x_d;
              y_q        <= y_d;
              state_q    <= ST_RAMWR_HI;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign PIX_VALID = pix_vld_q;
  assign PIX_X     = pix_x_q;
  assign PIX_Y     = pix_y_q;
  assign PIX_DATA  = pix_data_q;

`ifdef ST7735_RX_STATUS_EN
  logic       slp_q, disp_q, inv_q, colmod_pend_q;
  logic [7:0] colmod_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      slp_q         <= 1'b0;
      disp_q        <= 1'b0;
      inv_q         <= 1'b0;
      colmod_pend_q <= 1'b0;
      colmod_q      <= 8'h00;
    end else if (BYTE_VALID) begin
      // COLMOD takes only the byte immediately after 0x3A.
      colmod_pend_q <= 1'b0;
      if (BYTE_IS_CMD) begin
        case (BYTE)
          OP_SLPOUT:  slp_q  <= 1'b1;
          OP_SLPIN:   slp_q  <= 1'b0;
          OP_DISPON:  disp_q <= 1'b1;
          OP_DISPOFF: disp_q <= 1'b0;
          OP_INVON:   inv_q  <= 1'b1;
          OP_INVOFF:  inv_q  <= 1'b0;
          OP_COLMOD:  colmod_pend_q <= 1'b1;
          default: ;
        endcase
      end else if (colmod_pend_q) begin
        colmod_q <= BYTE;
      end
    end
  end

  assign SLEEP_OUT = slp_q;
  assign DISP_ON   = disp_q;
  assign INV_ON    = inv_q;
  assign COLMOD    = colmod_q;
`else
  assign SLEEP_OUT = 1'b0;
  assign DISP_ON   = 1'b0;
  assign INV_ON    = 1'b0;
  assign COLMOD    = 8'h00;
`endif

endmodule
